life_array_sequencer: RTL and testbench
=======================================

# life_array_sequencer

Host-side controller that drives a `life_array_16x16` cell array.
- Accepts a 16-row seed pattern over a valid/ready stream and writes it into the array row by row.
- Issues a requested number of generation steps.
- Scans all rows to detect a still life.
- Streams the resulting 16 rows back out over a second valid/ready stream.

It is the single source of `vali`, `vali_selector`, `write_enb`, `step` and `valo_selector` for the array, and the single consumer of `valo` and `valo_prev`.

## Interface
Parameters:
- `GEN_W`, 16: width of the generation count and generation counter.
- `STEP_GAP`, 2: low cycles between consecutive `arr_step` pulses, to let the array's combinational edge network settle. Legal range 1–15.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low; reset is asserted while `reset`=0.
- `load_start`  in  1  level, sampled in IDLE; starts a 16-row load.
- `run_req`  in  1  level, sampled in IDLE; starts a run.
- `gens`  in  GEN_W  generations to run; latched together with `run_req`.
- `row_in_valid`, `row_in_data[15:0]`  in; `row_in_ready`  out  1  seed row stream, row 0 first.
- `row_out_valid`  out  1; `row_out_data`  out  16; `row_out_last`  out  1; `row_out_ready`  in  1  result row stream.
- `busy`  out  1  high whenever state≠IDLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `stable`  out  1  after the last scan, every row has `valo`==`valo_prev`.
- `gen_count`  out  GEN_W  generations executed since the last load; wraps modulo 2^GEN_W.
- `arr_vali`  out  16; `arr_vali_selector`  out  4; `arr_write_enb`  out  1; `arr_step`  out  1; `arr_valo_selector`  out  4  array drive. All registered.
- `arr_valo`, `arr_valo_prev`  in  16 each  array read-back, combinational from `arr_valo_selector`.

## Operation
States: IDLE, LOAD, STEP, GAP, SCAN, DUMP.

IDLE
- `load_start`=1 → LOAD; row index=0, `gen_count`=0, `stable`=0.
- Else `run_req`=1 → latch `gens` into `remaining`. Go to STEP if `gens`>0, else DUMP.
- `load_start` has priority over `run_req` in the same cycle; the losing `run_req` is dropped.
- Requests in any other state are ignored.

LOAD
- `row_in_ready`=1.
- On each handshake: register `arr_vali`=`row_in_data`, `arr_vali_selector`=row index, and a one-cycle `arr_write_enb` pulse in the next cycle; then increment the row index.
- After the handshake at index 15 → IDLE.
- `row_in_ready`=0 outside LOAD.

STEP
- Drives exactly one one-cycle `arr_step` pulse.
- Decrements `remaining` and increments `gen_count`, then → GAP.

GAP
- Holds for STEP_GAP cycles.
- Then → STEP if `remaining`≠0, else → SCAN with `arr_valo_selector`=0.

SCAN
- Runs 16 cycles. In each cycle, compare `arr_valo` with `arr_valo_prev` for the current selector, then advance the selector.
- `stable` = AND of all 16 compares, updated on leaving SCAN.
- Then → DUMP with selector=0.

DUMP
- `row_out_valid`=1 and `row_out_data`=`arr_valo`.
- `row_out_last`=1 when selector=15.
- On handshake, advance the selector. The data is stable while valid=1 and ready=0 because the selector is held.
- After the last handshake → IDLE, with `done`=1 in that cycle.

Invariant: `arr_step` and `arr_write_enb` are never high in the same cycle.

## Timing
- Reset values: state IDLE; all outputs 0, including `arr_*`, `gen_count`, `stable`, `done`, `busy`, `row_in_ready` and `row_out_valid`.
- Reset asserted mid-operation aborts immediately. Array contents are not cleared by this block.
- Load: `row_in_ready` rises 1 cycle after `load_start` is sampled. One row per cycle is accepted at full throughput. `arr_write_enb` lags each handshake by 1 cycle.
- Run with N>0: the first `arr_step` occurs 2 cycles after `run_req` is sampled. Pulses are spaced N×(STEP_GAP+1) cycles overall. SCAN starts STEP_GAP cycles after the last pulse and lasts 16 cycles. DUMP row 0 is valid the next cycle.
- Run with N=0: DUMP row 0 is valid 1 cycle after `run_req`; `stable` is unchanged.
- With `row_out_ready` held high, the dump takes 16 cycles; `done` coincides with the row 15 handshake.

## Structure
- Package `life_ctrl_pkg`: state enum, `ROWS`=16, `SEL_W`=4, row-index type.
- A single module; no sub-module is warranted. The row index is shared by LOAD, SCAN and DUMP.

## Test plan
Bench: all array edge inputs (`ni`/`ei`/`si`/`wi` and corners) tied to 0.
- Reset: drive `reset`=0 mid-LOAD → all outputs read 0 and state is IDLE on the next edge, with no clock required.
- Blinker: load row 7=16'h0380, all others 0; run `gens`=1 → dump rows 6, 7, 8=16'h0100, others 0; `stable`=0; `gen_count`=1.
- Blinker continued: `gens`=1 again → dump row 7=16'h0380 restored; `gen_count`=2.
- Block: load rows 7, 8=16'h0180; run `gens`=3 → rows unchanged; `stable`=1; `gen_count`=3; exactly 3 `arr_step` pulses, each followed by ≥STEP_GAP low cycles.
- Backpressure and priority:
  - Toggle `row_out_ready` randomly during DUMP → data never changes while stalled; exactly 16 beats, with `last` only on the 16th.
  - Assert `load_start` and `run_req` together in IDLE → LOAD is entered and no step occurs.
- Zero generations: run `gens`=0 → no `arr_step`; dump equals the loaded pattern; `stable` is unchanged.

Source files
------------

// File: rtl/life_ctrl_pkg.sv
// Shared types and sizes for the life array host sequencer.
package life_ctrl_pkg;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned SEL_W = 4;

  typedef logic [SEL_W-1:0] row_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_GAP  = 3'd3,
    ST_SCAN = 3'd4,
    ST_DUMP = 3'd5
  } state_e;

endpackage

// File: rtl/life_array_sequencer.sv
// Host sequencer for a 16x16 life array: seed load, stepping, still-life scan, result dump.
module life_array_sequencer
  import life_ctrl_pkg::*;
#(
  parameter int unsigned GEN_W    = 16,
  parameter int unsigned STEP_GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             run_req,
  input  logic [GEN_W-1:0] gens,
  input  logic             row_in_valid,
  input  logic [15:0]      row_in_data,
  output logic             row_in_ready,
  output logic             row_out_valid,
  output logic [15:0]      row_out_data,
  output logic             row_out_last,
  input  logic             row_out_ready,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count,
  output logic [15:0]      arr_vali,
  output logic [3:0]       arr_vali_selector,
  output logic             arr_write_enb,
  output logic             arr_step,
  output logic [3:0]       arr_valo_selector,
  input  logic [15:0]      arr_valo,
  input  logic [15:0]      arr_valo_prev
);

  localparam row_idx_t   LAST_ROW = row_idx_t'(ROWS - 1);
  localparam logic [3:0] GAP_LAST = 4'(STEP_GAP - 1);

  state_e           state_q;
  row_idx_t         idx_q;
  logic [GEN_W-1:0] remaining_q;
  logic [3:0]       gap_q;
  logic             scan_ok_q;
  logic             row_in_ready_q, row_out_valid_q, row_out_last_q;
  logic             busy_q, done_q, stable_q;
  logic [GEN_W-1:0] gen_count_q;
  logic [15:0]      arr_vali_q;
  row_idx_t         arr_vali_sel_q;
  logic             arr_write_enb_q, arr_step_q;

  logic in_hs, out_hs, row_match;
  assign in_hs     = row_in_valid & row_in_ready_q;
  assign out_hs    = row_out_valid_q & row_out_ready;
  assign row_match = (arr_valo == arr_valo_prev);

  // Sequencer FSM: all control and array-drive outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      remaining_q     <= '0;
      gap_q           <= '0;
      scan_ok_q       <= 1'b0;
      row_in_ready_q  <= 1'b0;
      row_out_valid_q <= 1'b0;
      row_out_last_q  <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      stable_q        <= 1'b0;
      gen_count_q     <= '0;
      arr_vali_q      <= '0;
      arr_vali_sel_q  <= '0;
      arr_write_enb_q <= 1'b0;
      arr_step_q      <= 1'b0;
    end else begin
      arr_write_enb_q <= 1'b0;
      arr_step_q      <= 1'b0;
      done_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q        <= ST_LOAD;
            idx_q          <= '0;
            gen_count_q    <= '0;
            stable_q       <= 1'b0;
            row_in_ready_q <= 1'b1;
            busy_q         <= 1'b1;
          end else if (run_req) begin
            remaining_q <= gens;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            if (gens != '0) begin
              state_q <= ST_STEP;
            end else begin
              state_q         <= ST_DUMP;
              row_out_valid_q <= 1'b1;
              row_out_last_q  <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (in_hs) begin
            arr_vali_q      <= row_in_data;
            arr_vali_sel_q  <= idx_q;
            arr_write_enb_q <= 1'b1;
            idx_q           <= idx_q + row_idx_t'(1);
            if (idx_q == LAST_ROW) begin
              state_q        <= ST_IDLE;
              row_in_ready_q <= 1'b0;
              busy_q         <= 1'b0;
            end
          end
        end
        ST_STEP: begin
          arr_step_q  <= 1'b1;
          remaining_q <= remaining_q - GEN_W'(1);
          gen_count_q <= gen_count_q + GEN_W'(1);
          gap_q       <= '0;
          state_q     <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (remaining_q != '0) begin
              state_q <= ST_STEP;
            end else begin
              state_q   <= ST_SCAN;
              idx_q     <= '0;
              scan_ok_q <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + 4'(1);
          end
        end
        ST_SCAN: begin
          scan_ok_q <= scan_ok_q & row_match;
          if (idx_q == LAST_ROW) begin
            stable_q        <= scan_ok_q & row_match;
            state_q         <= ST_DUMP;
            idx_q           <= '0;
            row_out_valid_q <= 1'b1;
            row_out_last_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + row_idx_t'(1);
          end
        end
        ST_DUMP: begin
          if (out_hs) begin
            if (idx_q == LAST_ROW) begin
              state_q         <= ST_IDLE;
              idx_q           <= '0;
              row_out_valid_q <= 1'b0;
              row_out_last_q  <= 1'b0;
              done_q          <= 1'b1;
              busy_q          <= 1'b0;
            end else begin
              idx_q          <= idx_q + row_idx_t'(1);
              row_out_last_q <= (idx_q == LAST_ROW - row_idx_t'(1));
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Result data is the array read-back for the held selector.
  assign row_out_data      = arr_valo;
  assign row_in_ready      = row_in_ready_q;
  assign row_out_valid     = row_out_valid_q;
  assign row_out_last      = row_out_last_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign stable            = stable_q;
  assign gen_count         = gen_count_q;
  assign arr_vali          = arr_vali_q;
  assign arr_vali_selector = arr_vali_sel_q;
  assign arr_write_enb     = arr_write_enb_q;
  assign arr_step          = arr_step_q;
  assign arr_valo_selector = idx_q;

endmodule

// File: tb/tb_life_array_sequencer.sv
// Directed bench for life_array_sequencer with a behavioural 16x16 life array (zero boundary).
module tb_life_array_sequencer;

  localparam int unsigned GEN_W    = 16;
  localparam int unsigned STEP_GAP = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_start, run_req;
  logic [GEN_W-1:0] gens;
  logic             row_in_valid;
  logic [15:0]      row_in_data;
  logic             row_in_ready;
  logic             row_out_valid, row_out_last, row_out_ready;
  logic [15:0]      row_out_data;
  logic             busy, done, stable;
  logic [GEN_W-1:0] gen_count;
  logic [15:0]      arr_vali;
  logic [3:0]       arr_vali_selector, arr_valo_selector;
  logic             arr_write_enb, arr_step;
  logic [15:0]      arr_valo, arr_valo_prev;

  always #5 clk = ~clk;

  life_array_sequencer #(.GEN_W(GEN_W), .STEP_GAP(STEP_GAP)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .run_req(run_req), .gens(gens),
    .row_in_valid(row_in_valid), .row_in_data(row_in_data), .row_in_ready(row_in_ready),
    .row_out_valid(row_out_valid), .row_out_data(row_out_data), .row_out_last(row_out_last),
    .row_out_ready(row_out_ready),
    .busy(busy), .done(done), .stable(stable), .gen_count(gen_count),
    .arr_vali(arr_vali), .arr_vali_selector(arr_vali_selector), .arr_write_enb(arr_write_enb),
    .arr_step(arr_step), .arr_valo_selector(arr_valo_selector),
    .arr_valo(arr_valo), .arr_valo_prev(arr_valo_prev)
  );

  // Behavioural cell array: current and previous generation, edges tied to 0.
  logic [15:0] arr_cur  [16];
  logic [15:0] arr_prev [16];
  assign arr_valo      = arr_cur[arr_valo_selector];
  assign arr_valo_prev = arr_prev[arr_valo_selector];

  always @(posedge clk) begin
    if (arr_write_enb) arr_cur[arr_vali_selector] <= arr_vali;
    if (arr_step) begin
      for (int r = 0; r < 16; r++) begin
        logic [15:0] nr;
        nr = '0;
        for (int c = 0; c < 16; c++) begin
          int n;
          n = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 16 &&
                  (c + dc) >= 0 && (c + dc) < 16)
                n = n + int'(arr_cur[r + dr][c + dc]);
          nr[c] = (n == 3) || (arr_cur[r][c] && n == 2);
        end
        arr_prev[r] <= arr_cur[r];
        arr_cur[r]  <= nr;
      end
    end
  end

  // Step/write activity monitor.
  int cyc = 0, step_cnt = 0, we_cnt = 0, overlap_cnt = 0;
  int last_step_cyc = -1000, min_gap = 1000;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arr_step) begin
      step_cnt <= step_cnt + 1;
      if (cyc - last_step_cyc - 1 < min_gap) min_gap <= cyc - last_step_cyc - 1;
      last_step_cyc <= cyc;
    end
    if (arr_write_enb) we_cnt <= we_cnt + 1;
    if (arr_step && arr_write_enb) overlap_cnt <= overlap_cnt + 1;
  end

  int vecs = 0, errs = 0;
  logic [15:0] seed     [16];
  logic [15:0] exp_rows [16];
  logic [15:0] dump     [16];

  function automatic logic [47:0] all_outs();
    return {row_in_ready, row_out_valid, row_out_last, busy, done, stable, gen_count,
            arr_vali, arr_vali_selector, arr_write_enb, arr_step, arr_valo_selector};
  endfunction

  task automatic clear_patterns();
    for (int i = 0; i < 16; i++) begin
      seed[i]     = '0;
      exp_rows[i] = '0;
    end
  endtask

  // Load seed[] through the input stream at full throughput.
  task automatic load_seed();
    int t0;
    t0 = we_cnt;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    vecs++;
    if (row_in_ready !== 1'b1) begin
      errs++; $display("FAIL load_ready_rise: got %b expected 1", row_in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      row_in_valid = 1'b1; row_in_data = seed[i];
      @(negedge clk);
      vecs++;
      if ({arr_write_enb, arr_vali_selector, arr_vali} !== {1'b1, 4'(i), seed[i]}) begin
        errs++;
        $display("FAIL load_write row %0d: got we=%b sel=%0d vali=%h expected we=1 sel=%0d vali=%h",
                 i, arr_write_enb, arr_vali_selector, arr_vali, i, seed[i]);
      end
    end
    row_in_valid = 1'b0; row_in_data = '0;
    vecs++;
    if ({row_in_ready, busy} !== 2'b00) begin
      errs++; $display("FAIL load_end: got ready=%b busy=%b expected 0 0", row_in_ready, busy);
    end
    @(negedge clk);
    vecs++;
    if (we_cnt - t0 !== 16) begin
      errs++; $display("FAIL load_write_count: got %0d expected 16", we_cnt - t0);
    end
  endtask

  // Run n generations, check dump latency/steps/beats against exp_rows[].
  task automatic run_gens(input logic [15:0] n, input bit rand_rdy);
    int s0, k, beats, iters, bad;
    logic [15:0] held;
    bit stalled;
    s0 = step_cnt; k = 0; beats = 0; iters = 0; bad = 0; stalled = 0; held = '0;
    @(negedge clk); gens = n; run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    while (row_out_valid !== 1'b1 && k < 2000) begin
      @(negedge clk); k++;
    end
    vecs++;
    if (k !== int'(n) * (STEP_GAP + 1) + 16 * int'(n != 0)) begin
      errs++; $display("FAIL run_latency gens=%0d: got %0d expected %0d", n, k,
                       int'(n) * (STEP_GAP + 1) + 16 * int'(n != 0));
    end
    vecs++;
    if (step_cnt - s0 !== int'(n)) begin
      errs++; $display("FAIL step_count gens=%0d: got %0d expected %0d", n, step_cnt - s0, n);
    end
    while (beats < 16 && iters < 500) begin
      logic rdy;
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (row_out_valid === 1'b1) begin
        if (stalled && row_out_data !== held) bad++;
        if (rdy) begin
          dump[beats] = row_out_data;
          if (row_out_last !== (beats == 15)) bad++;
          beats++; stalled = 0;
        end else begin
          held = row_out_data; stalled = 1;
        end
      end else bad++;
      row_out_ready = rdy;
      @(negedge clk); iters++;
    end
    row_out_ready = 1'b0;
    vecs++;
    if (bad !== 0) begin
      errs++; $display("FAIL dump_stream gens=%0d: got %0d bad beats/stall/last events expected 0", n, bad);
    end
    if (!rand_rdy) begin
      vecs++;
      if (iters !== 16) begin
        errs++; $display("FAIL dump_cycles: got %0d expected 16", iters);
      end
    end
    vecs++;
    if ({done, busy, row_out_valid} !== 3'b100) begin
      errs++; $display("FAIL dump_done: got done=%b busy=%b valid=%b expected 1 0 0",
                       done, busy, row_out_valid);
    end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (dump[i] !== exp_rows[i]) begin
        errs++; $display("FAIL dump_row %0d: got %h expected %h", i, dump[i], exp_rows[i]);
      end
    end
    @(negedge clk);
    vecs++;
    if (done !== 1'b0) begin
      errs++; $display("FAIL done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 0; run_req = 0; gens = '0;
    row_in_valid = 0; row_in_data = '0; row_out_ready = 0;
    #2 reset = 1'b0;
    #1;
    vecs++;
    if (all_outs() !== 48'h0) begin
      errs++; $display("FAIL reset_initial: got %h expected 0", all_outs());
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0; row_in_valid = 1'b1; row_in_data = 16'hA5A5;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if ({busy, row_in_ready, arr_write_enb, arr_vali} !== {3'b111, 16'hA5A5}) begin
      errs++; $display("FAIL mid_load: got busy=%b rdy=%b we=%b vali=%h expected 1 1 1 a5a5",
                       busy, row_in_ready, arr_write_enb, arr_vali);
    end
    #2 reset = 1'b0;
    #1;
    vecs++;
    if (all_outs() !== 48'h0) begin
      errs++; $display("FAIL reset_async: got %h expected 0", all_outs());
    end
    row_in_valid = 1'b0; row_in_data = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vecs++;
    if ({busy, row_in_ready} !== 2'b00) begin
      errs++; $display("FAIL reset_idle: got busy=%b rdy=%b expected 0 0", busy, row_in_ready);
    end
  endtask

  task automatic test_blinker();
    clear_patterns();
    seed[7] = 16'h0380;
    load_seed();
    exp_rows[6] = 16'h0100; exp_rows[7] = 16'h0100; exp_rows[8] = 16'h0100;
    run_gens(16'd1, 1'b0);
    vecs++;
    if ({stable, gen_count} !== {1'b0, 16'd1}) begin
      errs++; $display("FAIL blinker_status: got stable=%b gen=%0d expected 0 1", stable, gen_count);
    end
    clear_patterns();
    exp_rows[7] = 16'h0380;
    run_gens(16'd1, 1'b0);
    vecs++;
    if ({stable, gen_count} !== {1'b0, 16'd2}) begin
      errs++; $display("FAIL blinker2_status: got stable=%b gen=%0d expected 0 2", stable, gen_count);
    end
  endtask

  task automatic test_block();
    clear_patterns();
    seed[7] = 16'h0180; seed[8] = 16'h0180;
    load_seed();
    exp_rows[7] = 16'h0180; exp_rows[8] = 16'h0180;
    run_gens(16'd3, 1'b0);
    vecs++;
    if ({stable, gen_count} !== {1'b1, 16'd3}) begin
      errs++; $display("FAIL block_status: got stable=%b gen=%0d expected 1 3", stable, gen_count);
    end
    vecs++;
    if (min_gap !== int'(STEP_GAP)) begin
      errs++; $display("FAIL step_gap: got %0d expected %0d", min_gap, STEP_GAP);
    end
  endtask

  task automatic test_back_to_back();
    run_gens(16'd1, 1'b1);
    vecs++;
    if ({stable, gen_count} !== {1'b1, 16'd4}) begin
      errs++; $display("FAIL backpressure_status: got stable=%b gen=%0d expected 1 4", stable, gen_count);
    end
  endtask

  task automatic test_zero_gens();
    run_gens(16'd0, 1'b0);
    vecs++;
    if ({stable, gen_count} !== {1'b1, 16'd4}) begin
      errs++; $display("FAIL zero_gens_status: got stable=%b gen=%0d expected 1 4", stable, gen_count);
    end
  endtask

  task automatic test_priority();
    int s0;
    s0 = step_cnt;
    clear_patterns();
    seed[7] = 16'h0380;
    @(negedge clk); load_start = 1'b1; run_req = 1'b1; gens = 16'd5;
    @(negedge clk); load_start = 1'b0; run_req = 1'b0;
    vecs++;
    if (row_in_ready !== 1'b1) begin
      errs++; $display("FAIL priority_load: got ready=%b expected 1", row_in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      row_in_valid = 1'b1; row_in_data = seed[i];
      @(negedge clk);
    end
    row_in_valid = 1'b0; row_in_data = '0;
    repeat (4) @(negedge clk);
    vecs++;
    if ({step_cnt - s0, busy, stable, gen_count} !== {32'd0, 2'b00, 16'd0}) begin
      errs++; $display("FAIL priority_no_run: got steps=%0d busy=%b stable=%b gen=%0d expected 0 0 0 0",
                       step_cnt - s0, busy, stable, gen_count);
    end
    exp_rows[7] = 16'h0380;
    run_gens(16'd0, 1'b0);
    vecs++;
    if ({stable, gen_count} !== {1'b0, 16'd0}) begin
      errs++; $display("FAIL priority_zero_status: got stable=%b gen=%0d expected 0 0", stable, gen_count);
    end
    vecs++;
    if (overlap_cnt !== 0) begin
      errs++; $display("FAIL step_write_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_back_to_back();
    test_zero_gens();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
